// File: rtl/typhoon_sched_pkg.sv
// -----------------------------------------------------------------------------
// typhoon_sched_pkg
// Shared types for the tile raster scheduler and the pixel shader it drives.
//   sched_state_t    : scheduler FSM states
//   box_t            : triangle bounding box as returned by the triangle store
//                      (x_min, y_min inclusive; x_max, y_max exclusive)
//   TILE_DIM_DEFAULT : nanotile edge, must agree with the shader nanoTileDim
// -----------------------------------------------------------------------------
package typhoon_sched_pkg;

  localparam int unsigned TILE_DIM_DEFAULT = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_CLEAR_ISSUE,
    ST_CLEAR_WAIT,
    ST_FETCH,
    ST_CULL,
    ST_TRI_ISSUE,
    ST_TRI_WAIT,
    ST_ADVANCE,
    ST_PUBLISH
  } sched_state_t;

  typedef struct packed {
    logic [9:0] x_min;
    logic [9:0] y_min;
    logic [9:0] x_max;
    logic [9:0] y_max;
  } box_t;

endpackage

// File: rtl/tile_raster_scheduler_cull.sv
// -----------------------------------------------------------------------------
// tile_cull_test
// Combinational overlap test between a triangle bounding box and the current
// TILE_DIM x TILE_DIM tile. Only compiled when TILE_CULL_EN is defined; the
// default build rasters every triangle on every tile and never needs it.
//   box_i    : bounding box (max edges exclusive)
//   org_x_i  : tile origin x
//   org_y_i  : tile origin y
//   hit_o    : 1 when the box touches at least one pixel of the tile
// -----------------------------------------------------------------------------
`ifdef TILE_CULL_EN
module tile_cull_test
  import typhoon_sched_pkg::*;
#(
  parameter int unsigned TILE_DIM = TILE_DIM_DEFAULT
) (
  input  box_t       box_i,
  input  logic [9:0] org_x_i,
  input  logic [9:0] org_y_i,
  output logic       hit_o
);

  // Tile end computed in 11 bits so the last tile column/row cannot wrap.
  logic [10:0] tile_end_x;
  logic [10:0] tile_end_y;

  assign tile_end_x = {1'b0, org_x_i} + 11'(TILE_DIM);
  assign tile_end_y = {1'b0, org_y_i} + 11'(TILE_DIM);

  assign hit_o = ({1'b0, box_i.x_min} < tile_end_x) &&
                 (box_i.x_max > org_x_i) &&
                 ({1'b0, box_i.y_min} < tile_end_y) &&
                 (box_i.y_max > org_y_i);

endmodule
`endif

// File: rtl/tile_raster_scheduler.sv
// -----------------------------------------------------------------------------
// tile_raster_scheduler
// Walks one pixel_shader across the screen a tile at a time. For each tile it
// claims a ping-pong output buffer, runs a clear pass, then one raster pass per
// stored triangle, and hands the finished tile to the framebuffer writer.
//
// Optional build macro: TILE_CULL_EN -- skip triangles whose bounding box does
// not overlap the current tile (uses tile_cull_test).
//
// Ports
//   BOARD_CLK, reset_n           clock, synchronous active-low reset
//   frame_start, tri_count       start a frame / triangles in store (latched)
//   tri_idx, tri_box             store address / box returned one cycle later
//   tile_offset_x/_y             current tile origin to shader
//   raster_tile_id, clear_z      shader buffer select / clear pass
//   start_rasterizing            shader pass request
//   done_rasterizing             shader status (idle high, low = accepted)
//   tile_ready, ready_buf,       finished tile handoff to writer (level)
//   ready_x/_y
//   tile_ack                     writer consumed ready_* (pulse)
//   buf_release                  writer drained buffer i (one-hot pulse)
//   frame_done                   pulse after the last tile is published
//   busy                         scheduler not idle
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for frame_start
// WAIT_BUF    | waiting for buffer raster_tile_id to be free, then claim it
// CLEAR_ISSUE | clear pass requested, waiting for shader ACK
// CLEAR_WAIT  | clear pass accepted, waiting for completion
// FETCH       | triangle store read latency
// CULL        | decide whether the fetched triangle touches the tile
// TRI_ISSUE   | raster pass requested, waiting for shader ACK
// TRI_WAIT    | raster pass accepted, waiting for completion
// ADVANCE     | next triangle or finish the tile
// PUBLISH     | hand tile to writer, step origin and buffer
// -----------------------------------------------------------------------------
module tile_raster_scheduler
  import typhoon_sched_pkg::*;
#(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned TILE_DIM  = TILE_DIM_DEFAULT,
  parameter int unsigned TRI_IDX_W = 8
) (
  input  logic                 BOARD_CLK,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic [TRI_IDX_W:0]   tri_count,
  output logic [TRI_IDX_W-1:0] tri_idx,
  input  box_t                 tri_box,
  output logic [9:0]           tile_offset_x,
  output logic [9:0]           tile_offset_y,
  output logic                 raster_tile_id,
  output logic                 clear_z,
  output logic                 start_rasterizing,
  input  logic                 done_rasterizing,
  output logic                 tile_ready,
  output logic                 ready_buf,
  output logic [9:0]           ready_x,
  output logic [9:0]           ready_y,
  input  logic                 tile_ack,
  input  logic [1:0]           buf_release,
  output logic                 frame_done,
  output logic                 busy
);

  localparam logic [9:0] TILE_STEP = 10'(TILE_DIM);
  localparam logic [9:0] LAST_X    = 10'(SCREEN_W - TILE_DIM);
  localparam logic [9:0] LAST_Y    = 10'(SCREEN_H - TILE_DIM);

  sched_state_t         state_q,      state_d;
  logic [TRI_IDX_W:0]   tri_cnt_q,    tri_cnt_d;
  logic [TRI_IDX_W-1:0] tri_idx_q,    tri_idx_d;
  logic [9:0]           org_x_q,      org_x_d;
  logic [9:0]           org_y_q,      org_y_d;
  logic                 rtid_q,       rtid_d;
  logic [1:0]           buf_busy_q,   buf_busy_d;
  logic                 tile_ready_q, tile_ready_d;
  logic                 ready_buf_q,  ready_buf_d;
  logic [9:0]           ready_x_q,    ready_x_d;
  logic [9:0]           ready_y_q,    ready_y_d;
  logic                 frame_done_q, frame_done_d;

  logic                 cull_hit;
  logic [1:0]           buf_free;
  logic [TRI_IDX_W:0]   adv_idx;
  logic                 last_tile;
  logic                 ready_blocked;

`ifdef TILE_CULL_EN
  tile_cull_test #(
    .TILE_DIM (TILE_DIM)
  ) u_cull (
    .box_i   (tri_box),
    .org_x_i (org_x_q),
    .org_y_i (org_y_q),
    .hit_o   (cull_hit)
  );
`else
  logic unused_tri_box;
  assign unused_tri_box = ^tri_box;
  assign cull_hit       = 1'b1;
`endif

  always_ff @(posedge BOARD_CLK) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tri_cnt_q    <= '0;
      tri_idx_q    <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      rtid_q       <= 1'b0;
      buf_busy_q   <= 2'b00;
      tile_ready_q <= 1'b0;
      ready_buf_q  <= 1'b0;
      ready_x_q    <= '0;
      ready_y_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tri_cnt_q    <= tri_cnt_d;
      tri_idx_q    <= tri_idx_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      rtid_q       <= rtid_d;
      buf_busy_q   <= buf_busy_d;
      tile_ready_q <= tile_ready_d;
      ready_buf_q  <= ready_buf_d;
      ready_x_q    <= ready_x_d;
      ready_y_q    <= ready_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tri_cnt_d    = tri_cnt_q;
    tri_idx_d    = tri_idx_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    rtid_d       = rtid_q;
    ready_buf_d  = ready_buf_q;
    ready_x_d    = ready_x_q;
    ready_y_d    = ready_y_q;
    frame_done_d = 1'b0;

    // A release this cycle frees the buffer before any claim is applied, so a
    // same-cycle release+claim leaves the buffer busy for the new tile.
    buf_free     = ~buf_busy_q | buf_release;
    buf_busy_d   = buf_busy_q & ~buf_release;

    // An ack arriving while PUBLISH waits lets the next tile go out at once.
    ready_blocked = tile_ready_q & ~tile_ack;
    tile_ready_d  = ready_blocked;

    adv_idx   = {1'b0, tri_idx_q} + (TRI_IDX_W+1)'(1);
    last_tile = (org_x_q == LAST_X) && (org_y_q == LAST_Y);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          tri_cnt_d = tri_count;
          state_d   = ST_WAIT_BUF;
        end
      end

      ST_WAIT_BUF: begin
        if (buf_free[rtid_q]) begin
          buf_busy_d[rtid_q] = 1'b1;
          state_d            = ST_CLEAR_ISSUE;
        end
      end

      ST_CLEAR_ISSUE: begin
        if (!done_rasterizing) state_d = ST_CLEAR_WAIT;
      end

      ST_CLEAR_WAIT: begin
        if (done_rasterizing) begin
          if (tri_cnt_q == '0) begin
            state_d = ST_PUBLISH;
          end else begin
            tri_idx_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        state_d = ST_CULL;
      end

      ST_CULL: begin
        state_d = cull_hit ? ST_TRI_ISSUE : ST_ADVANCE;
      end

      ST_TRI_ISSUE: begin
        if (!done_rasterizing) state_d = ST_TRI_WAIT;
      end

      ST_TRI_WAIT: begin
        if (done_rasterizing) state_d = ST_ADVANCE;
      end

      ST_ADVANCE: begin
        tri_idx_d = adv_idx[TRI_IDX_W-1:0];
        state_d   = (adv_idx == tri_cnt_q) ? ST_PUBLISH : ST_FETCH;
      end

      ST_PUBLISH: begin
        if (!ready_blocked) begin
          tile_ready_d = 1'b1;
          ready_buf_d  = rtid_q;
          ready_x_d    = org_x_q;
          ready_y_d    = org_y_q;
          rtid_d       = ~rtid_q;
          if (last_tile) begin
            org_x_d      = '0;
            org_y_d      = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            if (org_x_q == LAST_X) begin
              org_x_d = '0;
              org_y_d = org_y_q + TILE_STEP;
            end else begin
              org_x_d = org_x_q + TILE_STEP;
            end
            state_d = ST_WAIT_BUF;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pass request and clear flag decode straight from the state register so a
  // reset drops them on the very next cycle.
  assign start_rasterizing = (state_q == ST_CLEAR_ISSUE) || (state_q == ST_CLEAR_WAIT) ||
                             (state_q == ST_TRI_ISSUE)   || (state_q == ST_TRI_WAIT);
  assign clear_z           = (state_q == ST_CLEAR_ISSUE) || (state_q == ST_CLEAR_WAIT);
  assign busy              = (state_q != ST_IDLE);

  assign tri_idx        = tri_idx_q;
  assign tile_offset_x  = org_x_q;
  assign tile_offset_y  = org_y_q;
  assign raster_tile_id = rtid_q;
  assign tile_ready     = tile_ready_q;
  assign ready_buf      = ready_buf_q;
  assign ready_x        = ready_x_q;
  assign ready_y        = ready_y_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_tile_raster_scheduler.sv
module tb_tile_raster_scheduler;
  import typhoon_sched_pkg::*;

  localparam int SW = 16;
  localparam int SH = 16;
  localparam int TD = 8;
  localparam int IW = 8;
`ifdef TILE_CULL_EN
  localparam bit CULL_EN = 1'b1;
`else
  localparam bit CULL_EN = 1'b0;
`endif

  logic BOARD_CLK = 1'b0;
  always #5 BOARD_CLK = ~BOARD_CLK;

  logic          reset_n;
  logic          frame_start;
  logic [IW:0]   tri_count;
  logic [IW-1:0] tri_idx;
  box_t          tri_box;
  logic [9:0]    tile_offset_x, tile_offset_y;
  logic          raster_tile_id, clear_z, start_rasterizing;
  logic          done_rasterizing;
  logic          tile_ready, ready_buf;
  logic [9:0]    ready_x, ready_y;
  logic          tile_ack;
  logic [1:0]    buf_release;
  logic          frame_done, busy;

  tile_raster_scheduler #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TILE_DIM(TD), .TRI_IDX_W(IW)
  ) dut (
    .BOARD_CLK(BOARD_CLK), .reset_n(reset_n), .frame_start(frame_start),
    .tri_count(tri_count), .tri_idx(tri_idx), .tri_box(tri_box),
    .tile_offset_x(tile_offset_x), .tile_offset_y(tile_offset_y),
    .raster_tile_id(raster_tile_id), .clear_z(clear_z),
    .start_rasterizing(start_rasterizing), .done_rasterizing(done_rasterizing),
    .tile_ready(tile_ready), .ready_buf(ready_buf), .ready_x(ready_x), .ready_y(ready_y),
    .tile_ack(tile_ack), .buf_release(buf_release),
    .frame_done(frame_done), .busy(busy)
  );

  // Triangle store: one cycle read latency.
  box_t store [256];
  always @(posedge BOARD_CLK) tri_box <= store[tri_idx];

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int pub_cnt = 0;
  bit chk_en = 1'b1;
  bit hold0 = 1'b0;
  bit rel0_req = 1'b0;
  bit ack_tri = 1'b0;
  bit model_buf = 1'b0;
  int sh_dmin = 0;
  int sh_dmax = 3;
  int ack_max = 3;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit clr; int x; int y; bit b; } pass_t;
  typedef struct { int x; int y; bit b; } pub_t;
  pass_t exp_pass[$];
  pub_t  exp_pub[$];

  function automatic bit touches(box_t bx, int ox, int oy);
    return !CULL_EN || ((int'(bx.x_min) < ox + TD) && (int'(bx.x_max) > ox) &&
                        (int'(bx.y_min) < oy + TD) && (int'(bx.y_max) > oy));
  endfunction

  task automatic build_expected(input int n);
    pass_t p;
    pub_t  q;
    exp_pass.delete();
    exp_pub.delete();
    for (int ty = 0; ty < SH / TD; ty++) begin
      for (int tx = 0; tx < SW / TD; tx++) begin
        p.clr = 1'b1; p.x = tx * TD; p.y = ty * TD; p.b = model_buf;
        exp_pass.push_back(p);
        for (int i = 0; i < n; i++) begin
          if (touches(store[i], tx * TD, ty * TD)) begin
            p.clr = 1'b0;
            exp_pass.push_back(p);
          end
        end
        q.x = tx * TD; q.y = ty * TD; q.b = model_buf;
        exp_pub.push_back(q);
        model_buf = !model_buf;
      end
    end
  endtask

  // ---------------- shader model ----------------
  initial begin : shader
    logic       c0, r0;
    logic [9:0] x0, y0;
    int         d;
    pass_t      p;
    done_rasterizing = 1'b1;
    forever begin
      @(negedge BOARD_CLK);
      if (start_rasterizing === 1'b1) begin
        c0 = clear_z; r0 = raster_tile_id; x0 = tile_offset_x; y0 = tile_offset_y;
        if (chk_en) begin
          if (exp_pass.size() == 0) begin
            check_val("pass_unexpected", 1, 0);
          end else begin
            p = exp_pass.pop_front();
            check_val("pass_clear", c0, p.clr);
            check_val("pass_x", x0, p.x);
            check_val("pass_y", y0, p.y);
            check_val("pass_buf", r0, p.b);
          end
        end
        d = $urandom_range(sh_dmax, sh_dmin);
        repeat (d) begin
          @(negedge BOARD_CLK);
          if (chk_en) begin
            check_val("hold_start", start_rasterizing, 1);
            check_val("hold_cfg", {clear_z, raster_tile_id, tile_offset_x, tile_offset_y},
                      {c0, r0, x0, y0});
          end
        end
        done_rasterizing = 1'b0;
        if (!c0) ack_tri = 1'b1;
        @(negedge BOARD_CLK);
        if (chk_en) begin
          check_val("acked_start", start_rasterizing, 1);
          check_val("acked_cfg", {clear_z, raster_tile_id, tile_offset_x, tile_offset_y},
                    {c0, r0, x0, y0});
        end
        done_rasterizing = 1'b1;
        @(negedge BOARD_CLK);
        if (chk_en) check_val("start_drop", start_rasterizing, 0);
      end
    end
  end

  // ---------------- writer model ----------------
  initial begin : writer
    bit   wr_seen;
    int   wr_wait;
    pub_t q;
    wr_seen = 1'b0;
    wr_wait = 0;
    tile_ack = 1'b0;
    buf_release = 2'b00;
    forever begin
      @(negedge BOARD_CLK);
      tile_ack = 1'b0;
      buf_release = 2'b00;
      if (rel0_req) begin
        buf_release = 2'b01;
        rel0_req = 1'b0;
      end
      if (tile_ready !== 1'b1) begin
        wr_seen = 1'b0;
      end else begin
        if (!wr_seen) begin
          wr_seen = 1'b1;
          wr_wait = $urandom_range(ack_max, 0);
          pub_cnt++;
          if (chk_en) begin
            if (exp_pub.size() == 0) begin
              check_val("pub_unexpected", 1, 0);
            end else begin
              q = exp_pub.pop_front();
              check_val("pub_x", ready_x, q.x);
              check_val("pub_y", ready_y, q.y);
              check_val("pub_buf", ready_buf, q.b);
            end
          end
        end
        if (wr_wait == 0) begin
          tile_ack = 1'b1;
          if (!(hold0 && ready_buf == 1'b0))
            buf_release = buf_release | (ready_buf ? 2'b10 : 2'b01);
          wr_seen = 1'b0;
        end else begin
          wr_wait--;
        end
      end
    end
  end

  always @(negedge BOARD_CLK) if (frame_done === 1'b1) fd_cnt++;

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tri_idx"}, tri_idx, 0);
    check_val({tag, "_off_x"}, tile_offset_x, 0);
    check_val({tag, "_off_y"}, tile_offset_y, 0);
    check_val({tag, "_rtid"}, raster_tile_id, 0);
    check_val({tag, "_clear_z"}, clear_z, 0);
    check_val({tag, "_start"}, start_rasterizing, 0);
    check_val({tag, "_tile_ready"}, tile_ready, 0);
    check_val({tag, "_ready_buf"}, ready_buf, 0);
    check_val({tag, "_ready_x"}, ready_x, 0);
    check_val({tag, "_ready_y"}, ready_y, 0);
    check_val({tag, "_frame_done"}, frame_done, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  task automatic fill_full(input int n);
    for (int i = 0; i < n; i++) begin
      store[i].x_min = 10'd0;
      store[i].y_min = 10'd0;
      store[i].x_max = 10'(SW);
      store[i].y_max = 10'(SH);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      store[i].x_min = 10'($urandom_range(SW - 1, 0));
      store[i].y_min = 10'($urandom_range(SH - 1, 0));
      store[i].x_max = store[i].x_min + 10'($urandom_range(TD, 0));
      store[i].y_max = store[i].y_min + 10'($urandom_range(TD, 0));
    end
  endtask

  task automatic run_frame(input int n, input bit do_hold, input bit poke);
    int fd0;
    int pc0;
    bit seen;
    build_expected(n);
    fd0 = fd_cnt;
    pc0 = pub_cnt;
    hold0 = do_hold;
    @(negedge BOARD_CLK);
    frame_start = 1'b1;
    tri_count = (IW+1)'(n);
    @(negedge BOARD_CLK);
    frame_start = 1'b0;
    tri_count = (IW+1)'($urandom_range(7, 0));
    check_val("busy_set", busy, 1);
    if (poke) begin
      repeat (4) @(negedge BOARD_CLK);
      check_val("poke_busy", busy, 1);
      frame_start = 1'b1;
      tri_count = (IW+1)'($urandom_range(7, 0));
      @(negedge BOARD_CLK);
      frame_start = 1'b0;
    end
    if (do_hold) begin
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
        @(negedge BOARD_CLK);
        if (pub_cnt - pc0 >= 2) seen = 1'b1;
      end
      check_val("hold_tile1_published", seen, 1);
      repeat (8) begin
        @(negedge BOARD_CLK);
        check_val("hold_stall_start", start_rasterizing, 0);
        check_val("hold_stall_busy", busy, 1);
      end
      hold0 = 1'b0;
      @(posedge BOARD_CLK);
      rel0_req = 1'b1;
      @(negedge BOARD_CLK);
      check_val("hold_before_release", start_rasterizing, 0);
      @(negedge BOARD_CLK);
      check_val("hold_resume", start_rasterizing, 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge BOARD_CLK);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check_val("frame_done_seen", seen, 1);
    if (seen) begin
      check_val("idle_at_done", busy, 0);
      @(negedge BOARD_CLK);
      check_val("frame_done_one_cycle", frame_done, 0);
      check_val("passes_left", exp_pass.size(), 0);
      check_val("tiles_left", exp_pub.size(), 0);
      check_val("frame_done_count", fd_cnt - fd0, 1);
    end
    exp_pass.delete();
    exp_pub.delete();
    repeat (8) @(negedge BOARD_CLK);
  endtask

  task automatic run_reset_mid_pass();
    bit seen;
    seen = 1'b0;
    fill_full(3);
    chk_en = 1'b0;
    ack_tri = 1'b0;
    @(negedge BOARD_CLK);
    frame_start = 1'b1;
    tri_count = (IW+1)'(3);
    @(negedge BOARD_CLK);
    frame_start = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge BOARD_CLK);
      if (ack_tri) seen = 1'b1;
    end
    check_val("reach_tri_wait", seen, 1);
    @(negedge BOARD_CLK);
    reset_n = 1'b0;
    @(negedge BOARD_CLK);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    ack_tri = 1'b0;
    model_buf = 1'b0;
    exp_pass.delete();
    exp_pub.delete();
    repeat (4) @(negedge BOARD_CLK);
    chk_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    reset_n = 1'b0;
    frame_start = 1'b0;
    tri_count = '0;
    for (int i = 0; i < 256; i++) store[i] = '0;
    repeat (3) @(negedge BOARD_CLK);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    run_frame(0, 1'b0, 1'b0);

    fill_full(2);
    run_frame(2, 1'b0, 1'b0);

    store[0].x_min = 10'd0; store[0].y_min = 10'd0;
    store[0].x_max = 10'd4; store[0].y_max = 10'd4;
    run_frame(1, 1'b0, 1'b0);

    fill_full(1);
    run_frame(1, 1'b1, 1'b0);

    sh_dmin = 5; sh_dmax = 5;
    fill_full(2);
    run_frame(2, 1'b0, 1'b0);
    sh_dmin = 0; sh_dmax = 3;

    for (int f = 0; f < 5; f++) begin
      n = (f == 0) ? $urandom_range(6, 1) : $urandom_range(6, 0);
      fill_rand(n);
      run_frame(n, 1'b0, f == 0);
    end

    run_reset_mid_pass();
    run_frame(3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/tile_raster_scheduler.md
Name: tile_raster_scheduler

Overview:
- Sequences one pixel_shader instance across the screen, one TILE_DIM x TILE_DIM nanotile at a time.
- Per tile it issues one clear pass (clearZ=1), then one raster pass per triangle in the triangle store.
- Alternates the shader's ping-pong output buffer (rasterTileID) and hands each finished tile to the framebuffer writer.
- Sits between the triangle store and the shader; the writer sits downstream.

Parameters:
SCREEN_W, 640, screen width in pixels (multiple of TILE_DIM)
SCREEN_H, 480, screen height in pixels (multiple of TILE_DIM)
TILE_DIM, 8, nanotile edge; matches shader nanoTileDim
TRI_IDX_W, 8, triangle index width (max 2^TRI_IDX_W triangles)

Ports:
BOARD_CLK  in  1  clock
reset_n  in  1  synchronous active-low reset
frame_start  in  1  pulse: begin a frame (ignored unless IDLE)
tri_count  in  TRI_IDX_W+1  triangles in store, sampled on frame_start
tri_idx  out  TRI_IDX_W  triangle store read address; store returns tri_box 1 cycle later
tri_box  in  4x10  x_min, y_min, x_max (excl), y_max (excl) of addressed triangle
tile_offset_x, tile_offset_y  out  10  current tile origin to shader
raster_tile_id  out  1  shader buffer select
clear_z  out  1  shader clearZ
start_rasterizing  out  1  shader startRasterizing
done_rasterizing  in  1  shader doneRasterizing (idle-high)
tile_ready  out  1  finished tile available to writer (level)
ready_buf  out  1  buffer holding finished tile
ready_x, ready_y  out  10  origin of finished tile
tile_ack  in  1  writer pulse: ready_buf consumed
buf_release  in  2  writer one-hot pulse: buffer drained, reusable
frame_done  out  1  one-cycle pulse after last tile published
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0; both buffers free; tile origin (0,0); raster_tile_id 0.
- Shader handshake: hold start_rasterizing=1 with clear_z, tile_offset, raster_tile_id stable.
  - Pass accepted on first cycle done_rasterizing=0 (ACK); pass complete on next cycle done_rasterizing=1.
  - start_rasterizing drops the cycle after completion; at least one low cycle before the next pass.
  - Config outputs change only while start_rasterizing=0.
- FSM:
  - IDLE: on frame_start, latch tri_count -> WAIT_BUF.
  - WAIT_BUF: stall while buffer raster_tile_id is busy; else mark busy -> CLEAR_ISSUE.
  - CLEAR_ISSUE/CLEAR_WAIT: clear_z=1 pass. Then if tri_count==0 -> PUBLISH, else tri_idx=0 -> FETCH.
  - FETCH: one cycle of store latency -> CULL.
  - CULL: overlap test (see Optional Feature). Pass -> TRI_ISSUE; fail -> ADVANCE.
  - TRI_ISSUE/TRI_WAIT: clear_z=0 pass.
  - ADVANCE: tri_idx+1; if it equals tri_count -> PUBLISH, else FETCH.
  - PUBLISH: if tile_ready still high (previous tile unacked), stall. Else set tile_ready, ready_buf=raster_tile_id, ready_x/y=origin.
    - Then toggle raster_tile_id and step the origin: x += TILE_DIM; wrap to 0 at SCREEN_W with y += TILE_DIM.
    - If the last tile (origin SCREEN_W-TILE_DIM, SCREEN_H-TILE_DIM) was published: pulse frame_done -> IDLE. Else -> WAIT_BUF.
- tile_ack clears tile_ready the same cycle. buf_release[i] frees buffer i. A simultaneous release of, and claim on, the same buffer resolves as free-then-claim; claim wins.
- buf_release on a free buffer: no effect. frame_start while busy: ignored.
- Reset mid-pass: scheduler drops start_rasterizing immediately. The shader returns to start via its done-state rule.

Optional Feature:
- Macro TILE_CULL_EN.
- Defined: CULL passes only when tri_box overlaps the tile: x_min < ox+TILE_DIM, x_max > ox, y_min < oy+TILE_DIM, y_max > oy (unsigned 10-bit, 11-bit sums).
- Undefined: CULL always passes; every triangle is rastered on every tile.

Decomposition:
- Package typhoon_sched_pkg holds:
  - the FSM state enum;
  - the box_t struct (four 10-bit fields);
  - a TILE_DIM-default constant shared with the shader.
- One sub-module, tile_cull_test: combinational box/tile overlap. It is instantiated only under TILE_CULL_EN.

Test Plan:
- SCREEN 16x16, tri_count=0, writer acks and releases immediately -> 4 clear passes; tiles published at (0,0),(8,0),(0,8),(8,8); buffers 0,1,0,1; frame_done once.
- tri_count=2, boxes cover the whole screen -> per tile exactly 1 clear + 2 raster passes; clear_z low on raster passes.
- TILE_CULL_EN, one box (0,0,4,4) on 16x16 -> raster pass only on tile (0,0); other tiles clear-only.
- Writer withholds buf_release for buffer 0 -> scheduler finishes tile 1 in buffer 1, then stalls in WAIT_BUF with start_rasterizing=0; resumes the cycle after release.
- Shader model delays the done_rasterizing drop by 5 cycles -> start_rasterizing held; no tile advance until ACK then completion.
- reset_n low during TRI_WAIT -> next cycle all outputs 0, state IDLE; a new frame_start runs a full frame correctly.
